mac_accumulator: RTL

Sequential multiply-accumulate stage directly downstream of the 16-bit signed multiplier. It consumes a programmed number of 16-bit two's-complement products through a valid/ready handshake and sums them into a saturating 16-bit accumulator. It then presents the sum with a sticky saturation flag on an output handshake. It turns the combinational multiplier into a usable dot-product unit for the ALU datapath.

---
 rtl/mac_accumulator_pkg.sv | 16 +
 rtl/mac_accumulator_if.sv | 26 ++
 rtl/mac_accumulator_sat_add16.sv | 26 ++
 rtl/mac_accumulator.sv | 70 +++++++
 4 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared types and constants for the saturating multiply-accumulate stage.
package mac_accumulator_pkg;

    localparam int W_DEF     = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/mac_accumulator_if.sv
// Control, product-input and result-output handshakes of the accumulator.
interface mac_accumulator_if #(
    parameter int W     = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_sat;
    logic             out_ready;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_accumulator_sat_add16.sv
// Two's-complement add that clamps to the signed rails instead of wrapping.
module sat_add16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);
    logic [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Top two bits of the extended sum disagree only on overflow.
    always_comb begin
        sum = wide[W-1:0];
        sat = 1'b0;
        if (wide[W:W-1] == 2'b01) begin
            sum = {1'b0, {(W-1){1'b1}}};
            sat = 1'b1;
        end else if (wide[W:W-1] == 2'b10) begin
            sum = {1'b1, {(W-1){1'b0}}};
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/mac_accumulator.sv
// Sums a programmed count of signed products into a saturating accumulator
// and hands the result, with a sticky saturation flag, to the consumer.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mac_accumulator_if.slave  bus
);
    state_t           state, state_nxt;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] remaining;
    logic             sat;
    logic [W-1:0]     add_sum;
    logic             add_sat;
    logic             in_hs;

    assign in_hs = (state == ST_ACC) && bus.in_valid;

    sat_add16 #(.W(W)) u_add (
        .a   (acc),
        .b   (bus.in_data),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start)
                         state_nxt = (bus.len == '0) ? ST_DONE : ST_ACC;
            ST_ACC:  if (in_hs && remaining == CNT_W'(1))
                         state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready)
                         state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else if (state == ST_IDLE && bus.start) begin
            acc       <= '0;
            remaining <= bus.len;
            sat       <= 1'b0;
        end else if (in_hs) begin
            acc       <= add_sum;
            remaining <= remaining - CNT_W'(1);
            sat       <= sat | add_sat;
        end
    end

    // Result bus is forced to zero outside DONE so stale sums never leak out.
    assign bus.busy      = (state != ST_IDLE);
    assign bus.in_ready  = (state == ST_ACC);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = (state == ST_DONE) ? acc : '0;
    assign bus.out_sat   = (state == ST_DONE) && sat;
endmodule
